// File: rtl/dmem_wait.sv
// Byte-addressed big-endian data memory with LATENCY wait states behind a
// valid/ready request and a single-cycle response pulse.
module dmem_wait #(
   parameter int unsigned SIZE    = 16384,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        write_enable,
   input  logic        mem_byte,
   input  logic        mem_half_word,
   input  logic        sign_extend,
   input  logic [0:31] addr,
   input  logic [0:31] data_in,
   output logic        resp_valid,
   output logic [0:31] data_out,
   output logic        misaligned
);

   localparam int unsigned AW = $clog2(SIZE);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [0:31]   wdata_q, wdata_d;
   logic [0:31]   rdata_q, rdata_d;
   logic          we_q, we_d, byte_q, byte_d, half_q, half_d, sext_q, sext_d;
   logic          live_q;
   logic          accept, enter_resp, mis_d;
   logic [AW-1:0] idx1, idx2, idx3;
   logic [7:0]    b0, b1, b2, b3;

   logic [7:0] mem [0:SIZE-1];

   function automatic logic is_misaligned(input logic b, input logic h, input logic [1:0] lo);
      return !b && ((h && lo[0]) || (!h && (lo != 2'b00)));
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         half_q  <= 1'b0;
         sext_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         half_q  <= half_d;
         sext_q  <= sext_d;
         live_q  <= 1'b1;
      end
   end

   assign accept = (state_q == IDLE) && live_q && req_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      byte_d  = byte_q;
      half_d  = half_q;
      sext_d  = sext_q;
      case (state_q)
         IDLE: if (accept) begin
            idx_d   = addr[32-AW:31];
            wdata_d = data_in;
            we_d    = write_enable;
            byte_d  = mem_byte;
            half_d  = mem_half_word;
            sext_d  = sign_extend;
            cnt_d   = 4'(LATENCY);
            state_d = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Commit path uses the *_d copies so LATENCY=0 acts on the request accepted this edge.
   assign enter_resp = (state_q != RESP) && (state_d == RESP);
   assign mis_d      = is_misaligned(byte_d, half_d, idx_d[1:0]);
   assign idx1       = idx_d + AW'(1);
   assign idx2       = idx_d + AW'(2);
   assign idx3       = idx_d + AW'(3);
   assign b0         = mem[idx_d];
   assign b1         = mem[idx1];
   assign b2         = mem[idx2];
   assign b3         = mem[idx3];

   always_comb begin
      rdata_d = rdata_q;
      if (enter_resp) begin
         if (mis_d || we_d)  rdata_d = '0;
         else if (byte_d)    rdata_d = {{24{sext_d & b0[7]}}, b0};
         else if (half_d)    rdata_d = {{16{sext_d & b0[7]}}, b0, b1};
         else                rdata_d = {b0, b1, b2, b3};
      end
   end

   always_ff @(posedge clock) begin
      if (enter_resp && we_d && !mis_d) begin
         if (byte_d) begin
            mem[idx_d] <= wdata_d[24:31];
         end else if (half_d) begin
            mem[idx_d] <= wdata_d[16:23];
            mem[idx1]  <= wdata_d[24:31];
         end else begin
            mem[idx_d] <= wdata_d[0:7];
            mem[idx1]  <= wdata_d[8:15];
            mem[idx2]  <= wdata_d[16:23];
            mem[idx3]  <= wdata_d[24:31];
         end
      end
   end

   always_comb begin
      req_ready  = (state_q == IDLE) && live_q;
      resp_valid = (state_q == RESP);
      data_out   = resp_valid ? rdata_q : '0;
      misaligned = resp_valid && is_misaligned(byte_q, half_q, idx_q[1:0]);
   end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: one LATENCY=2 instance and one LATENCY=0 instance
// sharing request wires, selected by sel.
module tb_dmem_wait;

   logic        clock = 1'b0;
   logic        reset;
   logic        rv, we, mb, mh, se, sel;
   logic [31:0] addr, din;
   logic        rdy_a, rdy_b, rsp_a, rsp_b, mis_a, mis_b;
   logic [31:0] dout_a, dout_b;
   logic        rdy, rsp, mis;
   logic [31:0] dout;
   int          checks = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   dmem_wait #(.SIZE(16384), .LATENCY(2)) u_a (
      .clock(clock), .reset(reset), .req_valid(rv & ~sel), .req_ready(rdy_a),
      .write_enable(we), .mem_byte(mb), .mem_half_word(mh), .sign_extend(se),
      .addr(addr), .data_in(din), .resp_valid(rsp_a), .data_out(dout_a),
      .misaligned(mis_a)
   );

   dmem_wait #(.SIZE(16384), .LATENCY(0)) u_b (
      .clock(clock), .reset(reset), .req_valid(rv & sel), .req_ready(rdy_b),
      .write_enable(we), .mem_byte(mb), .mem_half_word(mh), .sign_extend(se),
      .addr(addr), .data_in(din), .resp_valid(rsp_b), .data_out(dout_b),
      .misaligned(mis_b)
   );

   assign rdy  = sel ? rdy_b  : rdy_a;
   assign rsp  = sel ? rsp_b  : rsp_a;
   assign mis  = sel ? mis_b  : mis_a;
   assign dout = sel ? dout_b : dout_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issues one request, returns response data, misaligned flag and the number
   // of edges from acceptance to the response becoming visible.
   task automatic req(input logic w, input logic b, input logic h, input logic s,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic rm, output int lat);
      int n;
      n   = 0;
      rd  = '0;
      rm  = 1'b0;
      lat = -1;
      @(negedge clock);
      while (!rdy && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!rdy) begin
         check("ready_timeout", {31'b0, rdy}, 32'd1);
         return;
      end
      rv = 1'b1; we = w; mb = b; mh = h; se = s; addr = a; din = d;
      @(posedge clock);
      #1;
      rv = 1'b0; we = ~w; mb = ~b; mh = ~h; se = ~s;
      addr = 32'hFFFF_FFFF; din = 32'h0BAD_0BAD;
      lat = 0;
      while (!rsp && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (!rsp) begin
         check("resp_timeout", {31'b0, rsp}, 32'd1);
         return;
      end
      rd = dout;
      rm = mis;
      check("ready_in_resp", {31'b0, rdy}, 32'd0);
      @(posedge clock);
      #1;
      check("resp_one_cycle", {31'b0, rsp}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        rm;
   int          lat;

   initial begin
      reset = 1'b0; rv = 1'b0; we = 1'b0; mb = 1'b0; mh = 1'b0; se = 1'b0;
      sel = 1'b0; addr = '0; din = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", {31'b0, rdy_a}, 32'd0);
      check("rst_resp", {31'b0, rsp_a}, 32'd0);
      check("rst_dout", dout_a, 32'd0);
      check("rst_mis", {31'b0, mis_a}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("ready_before_edge", {31'b0, rdy_a}, 32'd0);
      @(posedge clock);
      #1;
      check("ready_after_release", {31'b0, rdy_a}, 32'd1);

      // store word, latency 2
      req(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, rd, rm, lat);
      check("st_word_lat", lat, 32'd2);
      check("st_word_mis", {31'b0, rm}, 32'd0);
      check("mem10", {24'b0, u_a.mem[16'h10]}, 32'hDE);
      check("mem11", {24'b0, u_a.mem[16'h11]}, 32'hAD);
      check("mem12", {24'b0, u_a.mem[16'h12]}, 32'hBE);
      check("mem13", {24'b0, u_a.mem[16'h13]}, 32'hEF);

      // loads
      req(0, 1, 0, 1, 32'h11, 32'h0, rd, rm, lat);
      check("ld_byte_sx", rd, 32'hFFFFFFAD);
      req(0, 0, 1, 0, 32'h12, 32'h0, rd, rm, lat);
      check("ld_half_zx", rd, 32'h0000BEEF);
      req(0, 0, 0, 0, 32'h10, 32'h0, rd, rm, lat);
      check("ld_word", rd, 32'hDEADBEEF);
      check("ld_word_lat", lat, 32'd2);
      req(0, 1, 0, 0, 32'h12, 32'h0, rd, rm, lat);
      check("ld_byte_zx", rd, 32'h000000BE);

      // misaligned half store and word load
      req(1, 0, 1, 0, 32'h13, 32'h00001234, rd, rm, lat);
      check("mis_half_flag", {31'b0, rm}, 32'd1);
      check("mis_half_data", rd, 32'd0);
      check("mis_mem13", {24'b0, u_a.mem[16'h13]}, 32'hEF);
      req(0, 0, 0, 0, 32'h10, 32'h0, rd, rm, lat);
      check("after_mis_word", rd, 32'hDEADBEEF);
      req(0, 0, 0, 0, 32'h12, 32'h0, rd, rm, lat);
      check("mis_word_flag", {31'b0, rm}, 32'd1);
      check("mis_word_data", rd, 32'd0);

      // address wrap
      req(1, 1, 0, 0, 32'h4010, 32'h0000005A, rd, rm, lat);
      check("wrap_mem10", {24'b0, u_a.mem[16'h10]}, 32'h5A);
      req(0, 0, 0, 0, 32'h10, 32'h0, rd, rm, lat);
      check("wrap_word", rd, 32'h5AADBEEF);
      req(0, 0, 1, 1, 32'h10, 32'h0, rd, rm, lat);
      check("ld_half_sx_pos", rd, 32'h00005AAD);
      req(1, 0, 0, 0, 32'h3FFC, 32'h01020304, rd, rm, lat);
      req(0, 0, 0, 0, 32'h3FFC, 32'h0, rd, rm, lat);
      check("last_word", rd, 32'h01020304);
      check("last_word_mis", {31'b0, rm}, 32'd0);

      // LATENCY=0 back-to-back
      sel = 1'b1;
      req(1, 0, 0, 0, 32'h20, 32'h12345678, rd, rm, lat);
      check("l0_st_lat", lat, 32'd0);
      req(0, 0, 0, 0, 32'h20, 32'h0, rd, rm, lat);
      check("l0_ld_lat", lat, 32'd0);
      check("l0_ld_data", rd, 32'h12345678);
      req(0, 0, 1, 1, 32'h22, 32'h0, rd, rm, lat);
      check("l0_ld_half", rd, 32'h00005678);
      sel = 1'b0;

      // reset during WAIT drops the store
      req(1, 0, 0, 0, 32'h30, 32'hCAFEF00D, rd, rm, lat);
      @(negedge clock);
      rv = 1'b1; we = 1'b1; mb = 1'b0; mh = 1'b0; addr = 32'h30; din = 32'h11223344;
      @(posedge clock);
      #1;
      rv = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("abort_resp", {31'b0, rsp_a}, 32'd0);
      check("abort_ready", {31'b0, rdy_a}, 32'd0);
      repeat (2) begin
         @(posedge clock);
         #1;
         check("abort_no_resp", {31'b0, rsp_a}, 32'd0);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_mem30", {24'b0, u_a.mem[16'h30]}, 32'hCA);
      check("abort_mem33", {24'b0, u_a.mem[16'h33]}, 32'h0D);
      check("abort_ready_pre", {31'b0, rdy_a}, 32'd0);
      @(posedge clock);
      #1;
      check("abort_ready_post", {31'b0, rdy_a}, 32'd1);
      check("abort_resp_post", {31'b0, rsp_a}, 32'd0);
      req(0, 0, 0, 0, 32'h30, 32'h0, rd, rm, lat);
      check("abort_word", rd, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
